ram_dp_clr: RTL and testbench

Parametrised dual-port synchronous block RAM for arcade video/CPU memories: port A is the CPU read/write port, port B is a read-only video fetch port. After every reset an internal sequencer writes a fill value to every location before the RAM is handed over. The sequencer asserts `ready` when the clear completes. The block replaces single-port tile, colour and sprite RAMs wherever the video scanner and the CPU share storage.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clear_seq.sv | 50 +++++
 rtl/ram_dp_clr.sv | 88 ++++++++
 tb/tb_ram_dp_clr.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port clear-on-reset RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR,
    RUN
  } ram_clr_state_t;

  // Number of words addressed by an addr_width-bit address.
  function automatic int unsigned ram_depth(input int unsigned addr_width);
    return 32'(1) << addr_width;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: after every reset, walks the whole address space issuing
// fill writes, then switches to RUN and raises ready.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  run_o,
  output logic                  ready_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  ram_clr_state_t        state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  // FSM with registered ready; counter wraps to 0 on the last clear write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Memory is left alone during the reset cycle itself.
  assign clr_we_o   = (state_q == CLEAR) && !rst_i;
  assign clr_addr_o = cnt_q;
  assign run_o      = (state_q == RUN);
  assign ready_o    = ready_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port synchronous RAM: port A read/write (CPU), port B read-only (video).
// Contents are filled with CLEAR_VALUE after every reset before ready rises.
// Optional macro RAM_WR_BYPASS_EN selects write-first forwarding on both ports;
// without it both ports are read-first.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 11,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_wren,
  output logic [DATA_WIDTH-1:0] a_q,
  input  logic [ADDR_WIDTH-1:0] b_address,
  output logic [DATA_WIDTH-1:0] b_q,
  output logic                  ready
);

  localparam int unsigned Depth = ram_depth(ADDR_WIDTH);

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  run;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] a_rd_q;
  logic [DATA_WIDTH-1:0] b_rd_q;

  ram_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk_i     (clock),
    .rst_i     (reset),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .run_o     (run),
    .ready_o   (ready)
  );

  // Write port mux: sequencer owns it during clear, port A only in RUN.
  always_comb begin
    wr_en   = clr_we | (run & a_wren & ~reset);
    wr_addr = a_address;
    wr_data = a_data;
    if (clr_we) begin
      wr_addr = clr_addr;
      wr_data = CLEAR_VALUE;
    end
  end

  // Memory array, no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read data for both ports; fill value is shown while clearing.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else if (!run) begin
      a_rd_q <= CLEAR_VALUE;
      b_rd_q <= CLEAR_VALUE;
    end else begin
`ifdef RAM_WR_BYPASS_EN
      a_rd_q <= a_wren ? a_data : mem_q[a_address];
      b_rd_q <= (a_wren && (b_address == a_address)) ? a_data : mem_q[b_address];
`else
      a_rd_q <= mem_q[a_address];
      b_rd_q <= mem_q[b_address];
`endif
    end
  end

  assign a_q = a_rd_q;
  assign b_q = b_rd_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr (ADDR_WIDTH=4, CLEAR_VALUE=8'hA5).
module tb_ram_dp_clr;

  localparam int unsigned   Aw    = 4;
  localparam int unsigned   Dw    = 8;
  localparam int            Depth = 16;
  localparam logic [Dw-1:0] Cv    = 8'hA5;
`ifdef RAM_WR_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [Aw-1:0] a_address;
  logic [Dw-1:0] a_data;
  logic          a_wren;
  logic [Dw-1:0] a_q;
  logic [Aw-1:0] b_address;
  logic [Dw-1:0] b_q;
  logic          ready;

  ram_dp_clr #(
    .ADDR_WIDTH (Aw),
    .DATA_WIDTH (Dw),
    .CLEAR_VALUE(Cv)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .a_address(a_address),
    .a_data   (a_data),
    .a_wren   (a_wren),
    .a_q      (a_q),
    .b_address(b_address),
    .b_q      (b_q),
    .ready    (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: clear progress as a cycle count, memory as an array.
  logic [Dw-1:0] m_mem [Depth];
  int            m_cnt;
  logic          m_ready;
  logic [Dw-1:0] m_aq;
  logic [Dw-1:0] m_bq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [Aw-1:0] aa,
                            input logic [Dw-1:0] ad, input logic [Aw-1:0] ba);
    if (r) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_aq    = '0;
      m_bq    = '0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = Cv;
      m_aq = Cv;
      m_bq = Cv;
      m_cnt++;
      if (m_cnt == Depth) m_ready = 1'b1;
    end else begin
      m_aq = m_mem[aa];
      m_bq = m_mem[ba];
      if (w) begin
        if (Byp) begin
          m_aq = ad;
          if (ba == aa) m_bq = ad;
        end
        m_mem[aa] = ad;
      end
    end
  endtask

  // One clock: capture inputs, advance model at the edge, compare 1 time unit later.
  task automatic step();
    logic          r, w;
    logic [Aw-1:0] aa, ba;
    logic [Dw-1:0] ad;
    r = reset; w = a_wren; aa = a_address; ba = b_address; ad = a_data;
    @(posedge clock);
    model_edge(r, w, aa, ad, ba);
    #1;
    chk("model_a_q", 32'(a_q), 32'(m_aq));
    chk("model_b_q", 32'(b_q), 32'(m_bq));
    chk("model_ready", 32'(ready), 32'(m_ready));
  endtask

  task automatic drive(input logic w, input logic [Aw-1:0] aa, input logic [Dw-1:0] ad,
                       input logic [Aw-1:0] ba);
    a_wren = w; a_address = aa; a_data = ad; b_address = ba;
  endtask

  // Release reset and count edges until ready, bounded.
  task automatic wait_ready(input string name, input bit poke);
    int n = 0;
    do begin
      if (poke) drive(1'b1, 4'd2, 8'h3C, 4'd2);
      step();
      n++;
    end while (!ready && n < 40);
    chk(name, 32'(n), 32'd16);
    drive(1'b0, '0, '0, '0);
  endtask

  task automatic read_all(input string name, input logic [Dw-1:0] exp);
    for (int i = 0; i < Depth; i++) begin
      drive(1'b0, 4'(i), '0, 4'(Depth - 1 - i));
      step();
      chk({name, "_a"}, 32'(a_q), 32'(exp));
      chk({name, "_b"}, 32'(b_q), 32'(exp));
    end
  endtask

  typedef struct {
    logic          wren;
    logic [Aw-1:0] a_addr;
    logic [Dw-1:0] a_dat;
    logic [Aw-1:0] b_addr;
    logic [Dw-1:0] exp_a;
    logic [Dw-1:0] exp_b;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // Expectations assume a freshly cleared memory (all 8'hA5).
    vecs[0] = '{1'b1, 4'd7, 8'h11, 4'd7, Byp ? 8'h11 : 8'hA5, Byp ? 8'h11 : 8'hA5};
    vecs[1] = '{1'b0, 4'd7, 8'h00, 4'd7, 8'h11, 8'h11};
    vecs[2] = '{1'b1, 4'd5, 8'h11, 4'd0, Byp ? 8'h11 : 8'hA5, 8'hA5};
    vecs[3] = '{1'b1, 4'd5, 8'h22, 4'd5, Byp ? 8'h22 : 8'h11, Byp ? 8'h22 : 8'h11};
    vecs[4] = '{1'b0, 4'd5, 8'h00, 4'd5, 8'h22, 8'h22};
    vecs[5] = '{1'b1, 4'd2, 8'h3C, 4'd2, Byp ? 8'h3C : 8'hA5, Byp ? 8'h3C : 8'hA5};
    vecs[6] = '{1'b0, 4'd2, 8'h00, 4'd15, 8'h3C, 8'hA5};

    for (int i = 0; i < Depth; i++) m_mem[i] = '0;
    m_cnt = 0; m_ready = 1'b0; m_aq = '0; m_bq = '0;
    reset = 1'b1;
    drive(1'b0, '0, '0, '0);

    // Reset state.
    step();
    step();
    chk("rst_a_q", 32'(a_q), 32'h0);
    chk("rst_b_q", 32'(b_q), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);

    // Clear with port A trying to write address 2 throughout.
    reset = 1'b0;
    wait_ready("ready_latency", 1'b1);
    read_all("clear_fill", Cv);

    // Directed RUN vectors.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].wren, vecs[i].a_addr, vecs[i].a_dat, vecs[i].b_addr);
      step();
      chk($sformatf("vec%0d_a_q", i), 32'(a_q), 32'(vecs[i].exp_a));
      chk($sformatf("vec%0d_b_q", i), 32'(b_q), 32'(vecs[i].exp_b));
    end
    drive(1'b0, '0, '0, '0);

    // Reset at clear count 9 restarts the full clear.
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("midclr_not_ready", 32'(ready), 32'h0);
    reset = 1'b1; step();
    chk("midclr_rst_ready", 32'(ready), 32'h0);
    chk("midclr_rst_a_q", 32'(a_q), 32'h0);
    reset = 1'b0;
    wait_ready("midclr_latency", 1'b0);
    read_all("midclr_fill", Cv);

    // Fill with FF, then reset in RUN and confirm a full re-clear.
    for (int i = 0; i < Depth; i++) begin
      drive(1'b1, 4'(i), 8'hFF, 4'(i));
      step();
    end
    read_all("ff_fill", 8'hFF);
    reset = 1'b1; step();
    chk("runrst_a_q", 32'(a_q), 32'h0);
    chk("runrst_b_q", 32'(b_q), 32'h0);
    chk("runrst_ready", 32'(ready), 32'h0);
    reset = 1'b0;
    wait_ready("runrst_latency", 1'b0);
    read_all("runrst_fill", Cv);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 4'($urandom));
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
